// File: rtl/trans_phase_gen.sv
// Purpose: turns per-channel phase words into phase-shifted ~40 kHz square waves on trans.
//          Phase writes are double-buffered and take effect only at a period boundary.
//          Boards chain their sync: a master drives sync_out, a slave re-aligns to sync_in.
// Ports:   sys_clk/ext_rst (sync, active-high); enable; sync_slave/sync_in/sync_out;
//          phase_wr/phase_wr_data (shadow load); phases_active; update_pending;
//          period_start (1-cycle pulse); trans (registered drive outputs).
module trans_phase_gen #(
  parameter int NUM_CHANNELS = 4,
  parameter int PHASE_WIDTH  = 8,
  parameter int STEP_DIV     = 5
) (
  input  logic                                 sys_clk,
  input  logic                                 ext_rst,
  input  logic                                 enable,
  input  logic                                 sync_slave,
  input  logic                                 sync_in,
  output logic                                 sync_out,
  input  logic                                 phase_wr,
  input  logic [NUM_CHANNELS*PHASE_WIDTH-1:0]  phase_wr_data,
  output logic [NUM_CHANNELS*PHASE_WIDTH-1:0]  phases_active,
  output logic                                 update_pending,
  output logic                                 period_start,
  output logic [NUM_CHANNELS-1:0]              trans
);

  localparam int PW    = PHASE_WIDTH;
  localparam int DW    = NUM_CHANNELS * PHASE_WIDTH;
  localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(STEP_DIV - 1);

  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [PW-1:0]           step_q, step_d;
  logic [DW-1:0]           shadow_q, shadow_d;
  logic [DW-1:0]           active_q, active_d;
  logic                    pending_q, pending_d;
  logic                    pstart_q, pstart_d;
  logic [NUM_CHANNELS-1:0] trans_q, trans_d;
  logic                    sync_out_q, sync_out_d;
  logic                    s1_q, s2_q, s3_q;

  logic wrap;
  logic bnd;
  logic resync;
  logic period_evt;

  // A slave resync edge behaves exactly like a natural boundary, so a resync that
  // lands on the natural boundary still yields one update and one period_start.
  assign wrap       = (presc_q == PRE_MAX);
  assign bnd        = enable && wrap && (step_q == {PW{1'b1}});
  assign resync     = enable && sync_slave && s2_q && !s3_q;
  assign period_evt = bnd || resync;

  always_comb begin
    presc_d = presc_q;
    step_d  = step_q;
    if (!enable || resync) begin
      presc_d = '0;
      step_d  = '0;
    end else if (wrap) begin
      presc_d = '0;
      step_d  = step_q + PW'(1);
    end else begin
      presc_d = presc_q + PRE_W'(1);
    end
  end

  // While disabled there is no period to wait for, so writes go straight through
  // and any parked shadow is flushed into the active set.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (phase_wr) begin
      shadow_d = phase_wr_data;
    end
    if (!enable || period_evt) begin
      pending_d = 1'b0;
      if (phase_wr) begin
        active_d = phase_wr_data;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
    end else if (phase_wr) begin
      pending_d = 1'b1;
    end
  end

  // (step - phase) mod 2**PW below half a period is exactly "MSB of the difference clear".
  always_comb begin
    logic [PW-1:0] diff;
    diff    = '0;
    trans_d = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      diff       = step_q - active_q[i*PW +: PW];
      trans_d[i] = enable && !diff[PW-1];
    end
  end

  assign pstart_d   = period_evt;
  assign sync_out_d = sync_slave ? s2_q : (enable && !step_q[PW-1]);

  always_ff @(posedge sys_clk) begin
    if (ext_rst) begin
      presc_q    <= '0;
      step_q     <= '0;
      shadow_q   <= '0;
      active_q   <= '0;
      pending_q  <= 1'b0;
      pstart_q   <= 1'b0;
      trans_q    <= '0;
      sync_out_q <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      step_q     <= step_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      pstart_q   <= pstart_d;
      trans_q    <= trans_d;
      sync_out_q <= sync_out_d;
      s1_q       <= sync_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
    end
  end

  assign sync_out       = sync_out_q;
  assign phases_active  = active_q;
  assign update_pending = pending_q;
  assign period_start   = pstart_q;
  assign trans          = trans_q;

endmodule

// File: tb/tb_trans_phase_gen.sv
module tb_trans_phase_gen;

  logic        sys_clk;
  logic        ext_rst;
  logic        enable;
  logic        sync_slave;
  logic        sync_in;
  logic        sync_out;
  logic        phase_wr;
  logic [31:0] phase_wr_data;
  logic [31:0] phases_active;
  logic        update_pending;
  logic        period_start;
  logic [3:0]  trans;

  trans_phase_gen #(
    .NUM_CHANNELS(4),
    .PHASE_WIDTH (8),
    .STEP_DIV    (5)
  ) dut (
    .sys_clk       (sys_clk),
    .ext_rst       (ext_rst),
    .enable        (enable),
    .sync_slave    (sync_slave),
    .sync_in       (sync_in),
    .sync_out      (sync_out),
    .phase_wr      (phase_wr),
    .phase_wr_data (phase_wr_data),
    .phases_active (phases_active),
    .update_pending(update_pending),
    .period_start  (period_start),
    .trans         (trans)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          k;
    logic [3:0]  tr;
    logic        ps;
    logic        so;
    logic        pend;
    logic [31:0] act;
    logic        wr;
    logic [31:0] wd;
  } vec_t;

  vec_t vq[$];
  int   cyc;
  int   n_chk;
  int   n_err;

  // cyc counts rising edges since reset release; outputs are read 1 ns after each edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) tick();
  endtask

  task automatic wr(input logic [31:0] d);
    phase_wr      = 1'b1;
    phase_wr_data = d;
    tick();
    phase_wr      = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d2;
    d2 = 32'hFF80_4000;  // ch0=0 ch1=64 ch2=128 ch3=255
    n_chk = 0;
    n_err = 0;
    cyc   = 0;

    // Period boundaries fall every 1280 edges; trans after edge k reflects step ((k-1)/5)%256.
    //             k     tr    ps  so  pend  act    wr  wd
    vq.push_back('{1,    4'hF, 0, 1, 0, 32'h0, 0, 32'h0});
    vq.push_back('{640,  4'hF, 0, 1, 0, 32'h0, 0, 32'h0});
    vq.push_back('{641,  4'h0, 0, 0, 0, 32'h0, 0, 32'h0});
    vq.push_back('{1280, 4'h0, 1, 0, 0, 32'h0, 0, 32'h0});
    vq.push_back('{1281, 4'hF, 0, 1, 0, 32'h0, 0, 32'h0});
    vq.push_back('{1300, 4'hF, 0, 1, 0, 32'h0, 1, d2});
    vq.push_back('{1301, 4'hF, 0, 1, 1, 32'h0, 0, 32'h0});
    vq.push_back('{2559, 4'h0, 0, 0, 1, 32'h0, 0, 32'h0});
    vq.push_back('{2560, 4'h0, 1, 0, 0, d2,    0, 32'h0});
    vq.push_back('{2561, 4'h9, 0, 1, 0, d2,    0, 32'h0});
    vq.push_back('{2880, 4'h9, 0, 1, 0, d2,    0, 32'h0});
    vq.push_back('{2881, 4'hB, 0, 1, 0, d2,    0, 32'h0});
    vq.push_back('{3195, 4'hB, 0, 1, 0, d2,    0, 32'h0});
    vq.push_back('{3196, 4'h3, 0, 1, 0, d2,    0, 32'h0});
    vq.push_back('{3200, 4'h3, 0, 1, 0, d2,    0, 32'h0});
    vq.push_back('{3201, 4'h6, 0, 0, 0, d2,    0, 32'h0});
    vq.push_back('{3520, 4'h6, 0, 0, 0, d2,    0, 32'h0});
    vq.push_back('{3521, 4'h4, 0, 0, 0, d2,    0, 32'h0});
    vq.push_back('{3835, 4'h4, 0, 0, 0, d2,    0, 32'h0});
    vq.push_back('{3836, 4'hC, 0, 0, 0, d2,    0, 32'h0});
    vq.push_back('{3840, 4'hC, 1, 0, 0, d2,    0, 32'h0});
    vq.push_back('{3841, 4'h9, 0, 1, 0, d2,    0, 32'h0});

    ext_rst       = 1'b1;
    enable        = 1'b1;
    sync_slave    = 1'b0;
    sync_in       = 1'b0;
    phase_wr      = 1'b0;
    phase_wr_data = '0;
    tick();
    tick();
    ext_rst = 1'b0;
    cyc     = 0;

    // Reset state
    chk("rst_trans", 32'(trans), 32'h0);
    chk("rst_pstart", 32'(period_start), 32'h0);
    chk("rst_sync_out", 32'(sync_out), 32'h0);
    chk("rst_pending", 32'(update_pending), 32'h0);
    chk("rst_active", phases_active, 32'h0);

    // Free-running master, then staggered phases applied at the boundary
    foreach (vq[i]) begin
      run_to(vq[i].k);
      chk("vec_trans", 32'(trans), 32'(vq[i].tr));
      chk("vec_pstart", 32'(period_start), 32'(vq[i].ps));
      chk("vec_sync_out", 32'(sync_out), 32'(vq[i].so));
      chk("vec_pending", 32'(update_pending), 32'(vq[i].pend));
      chk("vec_active", phases_active, vq[i].act);
      if (vq[i].wr) wr(vq[i].wd);
    end

    // Write at step 100, overwritten before the boundary, then a write on the boundary
    run_to(4340);
    wr(32'h1122_3344);
    chk("wr1_pending", 32'(update_pending), 32'h1);
    chk("wr1_active_held", phases_active, d2);
    run_to(4500);
    wr(32'h5566_7788);
    chk("wr2_pending", 32'(update_pending), 32'h1);
    run_to(5119);
    chk("pre_bnd_active", phases_active, d2);
    tick();
    chk("bnd_active_last_wins", phases_active, 32'h5566_7788);
    chk("bnd_pending_clr", 32'(update_pending), 32'h0);
    chk("bnd_pstart", 32'(period_start), 32'h1);
    run_to(6000);
    wr(32'h0102_0304);
    chk("wr3_pending", 32'(update_pending), 32'h1);
    run_to(6399);
    wr(32'h00C0_8000);  // lands exactly on the boundary edge
    chk("bndwr_active", phases_active, 32'h00C0_8000);
    chk("bndwr_pending", 32'(update_pending), 32'h0);
    chk("bndwr_pstart", 32'(period_start), 32'h1);

    // Slave resync: sync_in rises at step 50 of the period starting at edge 6400
    sync_slave = 1'b1;
    run_to(6650);
    sync_in = 1'b1;
    tick();
    tick();
    chk("slv_pstart_early", 32'(period_start), 32'h0);
    chk("slv_sync_out_early", 32'(sync_out), 32'h0);
    tick();
    chk("slv_pstart", 32'(period_start), 32'h1);
    chk("slv_sync_out", 32'(sync_out), 32'h1);
    tick();
    chk("slv_trans_step0", 32'(trans), 32'hD);
    chk("slv_pstart_off", 32'(period_start), 32'h0);
    run_to(7293);
    chk("slv_trans_s127", 32'(trans), 32'h9);
    tick();
    chk("slv_trans_s128", 32'(trans), 32'h2);
    run_to(7932);
    chk("slv_freerun_pre", 32'(period_start), 32'h0);
    tick();
    chk("slv_freerun_bnd", 32'(period_start), 32'h1);
    sync_slave = 1'b0;
    sync_in    = 1'b0;

    // enable=0 mid-period with a pending write, direct write while disabled, re-enable
    run_to(8600);
    wr(32'h4040_4040);
    chk("en_wr_pending", 32'(update_pending), 32'h1);
    run_to(8633);
    enable = 1'b0;
    tick();
    chk("dis_trans", 32'(trans), 32'h0);
    chk("dis_sync_out", 32'(sync_out), 32'h0);
    chk("dis_pending", 32'(update_pending), 32'h0);
    chk("dis_active_flush", phases_active, 32'h4040_4040);
    run_to(8640);
    wr(32'h8080_0000);
    chk("dis_wr_active", phases_active, 32'h8080_0000);
    chk("dis_wr_pending", 32'(update_pending), 32'h0);
    run_to(8650);
    chk("dis_trans_hold", 32'(trans), 32'h0);
    enable = 1'b1;
    tick();
    chk("reen_trans", 32'(trans), 32'h3);
    chk("reen_pstart", 32'(period_start), 32'h0);
    chk("reen_sync_out", 32'(sync_out), 32'h1);
    run_to(9929);
    chk("reen_pre_bnd", 32'(period_start), 32'h0);
    tick();
    chk("reen_bnd", 32'(period_start), 32'h1);

    // Reset at step 200 while a write is pending
    run_to(9940);
    wr(32'h1234_5678);
    chk("rst_wr_pending", 32'(update_pending), 32'h1);
    run_to(10930);
    ext_rst = 1'b1;
    tick();
    ext_rst = 1'b0;
    chk("mid_rst_trans", 32'(trans), 32'h0);
    chk("mid_rst_pending", 32'(update_pending), 32'h0);
    chk("mid_rst_active", phases_active, 32'h0);
    chk("mid_rst_sync_out", 32'(sync_out), 32'h0);
    tick();
    chk("post_rst_trans", 32'(trans), 32'hF);
    run_to(12210);
    chk("post_rst_pre_bnd", 32'(period_start), 32'h0);
    tick();
    chk("post_rst_bnd", 32'(period_start), 32'h1);
    chk("post_rst_no_update", phases_active, 32'h0);
    chk("post_rst_pending", 32'(update_pending), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
